// File: rtl/ecc_scrub_ctrl.sv
// rtl/ecc_scrub_ctrl.sv - background SECDED scrubber sharing the array port with a functional requester
// Code: Hamming positions 1..72 (data on non-power-of-two positions), check bits 6:0, overall parity in bit 7.

module secded_hsyn (
  input  logic [64:0] data,
  output logic [6:0]  syn
);
  always_comb begin
    logic [6:0] j;
    syn = '0;
    j   = '0;
    for (int p = 1; p <= 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (data[j]) syn = syn ^ 7'(p);
        j = j + 7'd1;
      end
    end
  end
endmodule

module secded_enc (
  input  logic [64:0] data,
  output logic [7:0]  parity
);
  logic [6:0] hs;

  secded_hsyn u_hsyn (.data(data), .syn(hs));

  assign parity = {(^data) ^ (^hs), hs};
endmodule

module secded_dec (
  input  logic [64:0] data,
  input  logic [7:0]  parity,
  input  logic        bypass,
  output logic [64:0] data_out,
  output logic        sbit_err,
  output logic        dbit_err
);
  logic [6:0]  hs;
  logic [6:0]  syn;
  logic        overall;
  logic [64:0] mask;

  secded_hsyn u_hsyn (.data(data), .syn(hs));

  assign syn     = hs ^ parity[6:0];
  assign overall = (^data) ^ (^parity);

  // A syndrome naming a check-bit position (or zero with odd overall) leaves the mask empty.
  always_comb begin
    logic [6:0] j;
    mask = '0;
    j    = '0;
    for (int p = 1; p <= 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (syn == 7'(p)) mask[j] = 1'b1;
        j = j + 7'd1;
      end
    end
  end

  assign sbit_err = !bypass && overall && (syn <= 7'd72);
  assign dbit_err = !bypass && ((!overall && (syn != 7'd0)) || (overall && (syn > 7'd72)));
  assign data_out = bypass ? data : (data ^ mask);
endmodule

module ecc_scrub_ctrl #(
  parameter int DATA_WIDTH   = 65,
  parameter int PARITY_WIDTH = 8,
  parameter int ADDR_WIDTH   = 6,
  parameter int DEPTH        = 64,
  parameter int STARVE_LIMIT = 15,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    func_req,
  output logic                    func_gnt,
  output logic                    mem_rd_en,
  output logic                    mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data,
  input  logic [PARITY_WIDTH-1:0] mem_rd_parity,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic [PARITY_WIDTH-1:0] mem_wr_parity,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    sbe_cnt,
  output logic [CNT_WIDTH-1:0]    dbe_cnt,
  output logic [ADDR_WIDTH-1:0]   dbe_addr,
  output logic                    dbe_addr_vld
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_CHK, S_WB, S_NEXT} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [SW-1:0]           starve;
  logic                    lock;
  logic [DATA_WIDTH-1:0]   word_q;
  logic [PARITY_WIDTH-1:0] par_q;
  logic                    defer;
  logic                    rd_issue;
  logic                    sbit_err;
  logic                    dbit_err;

  secded_dec u_dec (
    .data     (word_q),
    .parity   (par_q),
    .bypass   (1'b0),
    .data_out (mem_wr_data),
    .sbit_err (sbit_err),
    .dbit_err (dbit_err)
  );

  secded_enc u_enc (
    .data   (mem_wr_data),
    .parity (mem_wr_parity)
  );

  assign defer     = (state == S_RD) && func_req && (starve < STARVE_MAX);
  assign rd_issue  = (state == S_RD) && !defer && !rst;
  assign mem_rd_en = rd_issue;
  assign mem_wr_en = (state == S_WB) && !rst;
  assign mem_addr  = addr;
  assign busy      = (state != S_IDLE);
  // The port stays with the scrubber from its read until the word is retired.
  assign func_gnt  = func_req && !rst && !lock && !rd_issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      addr         <= '0;
      starve       <= '0;
      lock         <= 1'b0;
      word_q       <= '0;
      par_q        <= '0;
      done         <= 1'b0;
      sbe_cnt      <= '0;
      dbe_cnt      <= '0;
      dbe_addr     <= '0;
      dbe_addr_vld <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr         <= '0;
            sbe_cnt      <= '0;
            dbe_cnt      <= '0;
            dbe_addr     <= '0;
            dbe_addr_vld <= 1'b0;
            starve       <= '0;
            state        <= S_RD;
          end
        end
        S_RD: begin
          if (defer) begin
            starve <= starve + 1'b1;
          end else begin
            starve <= '0;
            lock   <= 1'b1;
            state  <= S_CAP;
          end
        end
        S_CAP: begin
          word_q <= mem_rd_data;
          par_q  <= mem_rd_parity;
          state  <= S_CHK;
        end
        S_CHK: begin
          if (sbit_err) begin
            state <= S_WB;
          end else begin
            if (dbit_err) begin
              if (dbe_cnt != '1) dbe_cnt <= dbe_cnt + 1'b1;
              if (!dbe_addr_vld) begin
                dbe_addr     <= addr;
                dbe_addr_vld <= 1'b1;
              end
            end
            state <= S_NEXT;
          end
        end
        S_WB: begin
          if (sbe_cnt != '1) sbe_cnt <= sbe_cnt + 1'b1;
          state <= S_NEXT;
        end
        S_NEXT: begin
          lock <= 1'b0;
          if (addr == LAST_ADDR) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            addr  <= addr + 1'b1;
            state <= S_RD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb/tb_ecc_scrub_ctrl.sv - table-driven bench for the SECDED scrubber and port arbiter
module tb_ecc_scrub_ctrl;
  localparam int DW = 65, PW = 8, AW = 6, DEPTH = 64, CW = 16;

  logic          clk = 1'b0;
  logic          rst, start, func_req;
  logic          func_gnt, mem_rd_en, mem_wr_en, busy, done, dbe_addr_vld;
  logic [AW-1:0] mem_addr, dbe_addr;
  logic [DW-1:0] mem_rd_data = '0, mem_wr_data;
  logic [PW-1:0] mem_rd_parity = '0, mem_wr_parity;
  logic [CW-1:0] sbe_cnt, dbe_cnt;

  ecc_scrub_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .func_req(func_req), .func_gnt(func_gnt),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .mem_rd_parity(mem_rd_parity),
    .mem_wr_data(mem_wr_data), .mem_wr_parity(mem_wr_parity),
    .busy(busy), .done(done), .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt),
    .dbe_addr(dbe_addr), .dbe_addr_vld(dbe_addr_vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem_d[DEPTH], init_d[DEPTH], good_d[DEPTH];
  logic [PW-1:0] mem_p[DEPTH], init_p[DEPTH], good_p[DEPTH];
  bit            is_sbe[DEPTH];
  bit            load = 1'b0;
  int            pos[DW];

  always @(posedge clk) begin
    if (load) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_d[a] = init_d[a];
        mem_p[a] = init_p[a];
      end
    end else begin
      if (mem_rd_en) begin
        mem_rd_data   <= mem_d[mem_addr];
        mem_rd_parity <= mem_p[mem_addr];
      end
      if (mem_wr_en) begin
        mem_d[mem_addr] = mem_wr_data;
        mem_p[mem_addr] = mem_wr_parity;
      end
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Check bits are the XOR of the Hamming positions of all set data bits.
  function automatic logic [PW-1:0] enc(input logic [DW-1:0] d);
    logic [6:0] s;
    s = '0;
    for (int j = 0; j < DW; j++) if (d[j]) s = s ^ 7'(pos[j]);
    return {(^d) ^ (^s), s};
  endfunction

  typedef struct {
    logic [AW-1:0] a1; logic [DW-1:0] m1; logic [PW-1:0] pm1;
    logic [AW-1:0] a2; logic [DW-1:0] m2; logic [PW-1:0] pm2;
    bit req; int sbe; int dbe; logic [AW-1:0] dba; bit dbv; int done_cyc; int nwr;
  } vec_t;

  vec_t vt[8];

  task automatic fill_good();
    for (int a = 0; a < DEPTH; a++) good_d[a] = {1'($urandom), $urandom, $urandom};
    good_d[5] = 65'h1;
    for (int a = 0; a < DEPTH; a++) begin
      good_p[a] = enc(good_d[a]);
      init_d[a] = good_d[a];
      init_p[a] = good_p[a];
    end
  endtask

  task automatic load_mem();
    for (int a = 0; a < DEPTH; a++)
      is_sbe[a] = ($countones(init_d[a] ^ good_d[a]) + $countones(init_p[a] ^ good_p[a])) == 1;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run_pass(input vec_t v);
    int t0, c, exp_rd, last_rd, last_a, n_rd, n_wr, done_c, nmis;
    bit win;
    fill_good();
    init_d[v.a1] ^= v.m1; init_p[v.a1] ^= v.pm1;
    init_d[v.a2] ^= v.m2; init_p[v.a2] ^= v.pm2;
    load_mem();
    func_req = v.req;
    start = 1'b1;
    t0 = cyc;
    exp_rd = v.req ? 16 : 1;
    last_rd = -100; last_a = 0; n_rd = 0; n_wr = 0; done_c = -1;
    for (int k = 0; k < 3000 && done_c < 0; k++) begin
      @(negedge clk);
      c = cyc - t0;
      start = (c == 100);
      if (mem_rd_en) begin
        chk("rd_cycle", c, exp_rd);
        chk("rd_addr", mem_addr, n_rd);
        last_rd = c;
        last_a  = int'(mem_addr);
        exp_rd  = c + (is_sbe[mem_addr] ? 5 : 4) + (v.req ? 15 : 0);
        n_rd++;
      end
      if (mem_wr_en) begin
        n_wr++;
        chk("wb_is_sbe", is_sbe[mem_addr], 1);
        chk("wb_data", mem_wr_data, good_d[mem_addr]);
        chk("wb_parity", mem_wr_parity, good_p[mem_addr]);
        chk("wb_latency", c - last_rd, 3);
      end
      win = (c - last_rd) <= (is_sbe[last_a] ? 4 : 3);
      chk("gnt", func_gnt, v.req && !win);
      chk("busy", busy, c < v.done_cyc);
      if (done) done_c = c;
    end
    start = 1'b0;
    func_req = 1'b0;
    chk("done_cycle", done_c, v.done_cyc);
    chk("n_reads", n_rd, DEPTH);
    chk("n_writes", n_wr, v.nwr);
    chk("sbe_cnt", sbe_cnt, v.sbe);
    chk("dbe_cnt", dbe_cnt, v.dbe);
    chk("dbe_addr", dbe_addr, v.dba);
    chk("dbe_addr_vld", dbe_addr_vld, v.dbv);
    nmis = 0;
    for (int a = 0; a < DEPTH; a++)
      if (mem_d[a] !== (is_sbe[a] ? good_d[a] : init_d[a]) ||
          mem_p[a] !== (is_sbe[a] ? good_p[a] : init_p[a])) nmis++;
    chk("mem_after", nmis, 0);
    repeat (3) @(negedge clk);
    chk("hold_sbe", sbe_cnt, v.sbe);
    chk("hold_dbe_vld", dbe_addr_vld, v.dbv);
    chk("hold_idle", {busy, done}, 0);
  endtask

  initial begin
    int k, n;
    k = 0;
    for (int p = 1; p <= 72; p++) if ((p & (p - 1)) != 0) begin pos[k] = p; k++; end

    //        a1     m1                          pm1    a2     m2                          pm2    req sbe dbe dba    dbv done  nwr
    vt[0] = '{6'd0,  65'h0,                      8'h00, 6'd0,  65'h0,                      8'h00, 0,  0,  0,  6'd0,  0,  257,  0};
    vt[1] = '{6'd5,  65'h1,                      8'h00, 6'd0,  65'h0,                      8'h00, 0,  1,  0,  6'd0,  0,  258,  1};
    vt[2] = '{6'd9,  65'h0,                      8'h08, 6'd0,  65'h0,                      8'h00, 0,  1,  0,  6'd0,  0,  258,  1};
    vt[3] = '{6'd12, 65'h3,                      8'h00, 6'd40, 65'h1_0000_0000_0000_0400,  8'h00, 0,  0,  2,  6'd12, 1,  257,  0};
    vt[4] = '{6'd20, 65'h1_0000_0000_0000_0000,  8'h00, 6'd63, 65'h0,                      8'h80, 0,  2,  0,  6'd0,  0,  259,  2};
    vt[5] = '{6'd30, 65'h0_8000_0000_0000_0001,  8'h00, 6'd7,  65'h6,                      8'h00, 0,  0,  2,  6'd7,  1,  257,  0};
    vt[6] = '{6'd2,  65'h2_0000_0000,            8'h00, 6'd50, 65'h10,                     8'h01, 0,  1,  1,  6'd50, 1,  258,  1};
    vt[7] = '{6'd0,  65'h0,                      8'h00, 6'd0,  65'h0,                      8'h00, 1,  0,  0,  6'd0,  0,  1217, 0};

    rst = 1'b1; start = 1'b0; func_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {func_gnt, mem_rd_en, mem_wr_en, mem_addr, busy, done,
                        sbe_cnt, dbe_cnt, dbe_addr, dbe_addr_vld}, 0);
    chk("rst_wr_bus", {mem_wr_data, mem_wr_parity}, 0);
    rst = 1'b0;
    #1 chk("idle_gnt", func_gnt, 1);
    func_req = 1'b0;
    #1 chk("idle_no_req", func_gnt, 0);

    for (int i = 0; i < 8; i++) begin
      run_pass(vt[i]);
      if (i == 1) begin
        chk("w5_data", mem_d[5], 65'h1);
        chk("w5_parity", mem_p[5], 8'h83);
      end
    end

    // Reset landing in the write-back cycle of word 3.
    fill_good();
    init_d[3] ^= 65'h100;
    load_mem();
    start = 1'b1;
    k = cyc;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ((cyc - k) < 16 && n < 50) begin @(negedge clk); n++; end
    chk("wb3_en", mem_wr_en, 1);
    chk("wb3_addr", mem_addr, 3);
    rst = 1'b1;
    #1 chk("rst_in_wb_en", mem_wr_en, 0);
    @(negedge clk);
    chk("rst_after_busy", busy, 0);
    chk("rst_after_cnt", {sbe_cnt, dbe_cnt, done}, 0);
    rst = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_rd_en || mem_wr_en || busy) n++;
    end
    chk("no_resume", n, 0);
    chk("w3_untouched", mem_d[3], init_d[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
